// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared types, defaults and routing helpers for the tree router
package noc_pkg;

  localparam int DEF_WIDTH      = 35;
  localparam int DEF_WIDTH_ADDR = 3;

  // Widest configuration the helpers below accept.
  localparam int MAX_PORTS  = 9;
  localparam int MAX_FLIT_W = 256;
  localparam int MAX_ADDR_W = 16;

  typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;
  typedef logic [MAX_FLIT_W-1:0]        flit_t;
  typedef logic [MAX_ADDR_W-1:0]        addr_t;

  // Route code for a parent-side flit that does not belong to this subtree.
  localparam port_idx_t PORT_INVALID = '1;

  // Destination field sits in the top width_addr bits of the flit.
  function automatic addr_t dest_of(input flit_t flit, input int width, input int width_addr);
    flit_t shifted;
    addr_t field_mask;
    shifted    = flit >> (width - width_addr);
    field_mask = (addr_t'(1) << width_addr) - addr_t'(1);
    return addr_t'(shifted) & field_mask;
  endfunction

  // Port 0 is the parent, port k+1 is child k.
  function automatic port_idx_t route_of(input addr_t dest, input addr_t mask, input addr_t address,
                                         input int child_shift, input int num_child,
                                         input logic from_parent);
    addr_t child_sel;
    child_sel = (dest >> child_shift) & addr_t'(num_child - 1);
    if ((dest & mask) == (address & mask)) begin
      return port_idx_t'(child_sel) + port_idx_t'(1);
    end
    if (!from_parent) begin
      return '0;
    end
    return PORT_INVALID;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - synchronous per-output FIFO with occupancy count
module noc_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when it is popped in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  // Head reads as zero while empty so idle outputs carry no stale data.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_tree_router.sv
// rtl/noc_tree_router.sv - parent/child tree router node; NOC_ROUTER_STATS_EN adds stat_fwd/stat_drop counters
module noc_tree_router
  import noc_pkg::*;
#(
  parameter int                    WIDTH       = DEF_WIDTH,
  parameter int                    WIDTH_ADDR  = DEF_WIDTH_ADDR,
  parameter int                    NUM_CHILD   = 2,
  parameter logic [WIDTH_ADDR-1:0] MASK        = 3'b110,
  parameter logic [WIDTH_ADDR-1:0] ADDRESS     = 3'b010,
  parameter int                    CHILD_SHIFT = 0,
  parameter int                    FIFO_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           p_in_data,
  input  logic                       p_in_valid,
  output logic                       p_in_ready,
  output logic [WIDTH-1:0]           p_out_data,
  output logic                       p_out_valid,
  input  logic                       p_out_ready,
  input  logic [NUM_CHILD*WIDTH-1:0] c_in_data,
  input  logic [NUM_CHILD-1:0]       c_in_valid,
  output logic [NUM_CHILD-1:0]       c_in_ready,
  output logic [NUM_CHILD*WIDTH-1:0] c_out_data,
  output logic [NUM_CHILD-1:0]       c_out_valid,
  input  logic [NUM_CHILD-1:0]       c_out_ready,
  output logic                       route_err
`ifdef NOC_ROUTER_STATS_EN
  ,
  output logic [(NUM_CHILD+1)*16-1:0] stat_fwd,
  output logic [15:0]                 stat_drop
`endif
);

  localparam int P  = NUM_CHILD + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [WIDTH-1:0] in_data  [P];
  logic [P-1:0]     in_valid;
  logic [P-1:0]     in_ready;
  logic [WIDTH-1:0] out_data [P];
  logic [P-1:0]     out_valid;
  logic [P-1:0]     out_ready;
  logic [P-1:0]     pop;

  port_idx_t        route    [P];
  logic [P-1:0]     cand     [P];
  logic [P-1:0]     gnt      [P];
  port_idx_t        gnt_idx  [P];
  logic [P-1:0]     gnt_any;
  port_idx_t        rr_ptr   [P];
  logic [WIDTH-1:0] push_data [P];

  logic [CW-1:0]    fifo_count [P];
  logic [P-1:0]     fifo_full;
  logic [P-1:0]     fifo_empty;
  logic             drop;

  // Flatten parent and child ports into one index space: 0 = parent, k+1 = child k.
  assign in_data[0]   = p_in_data;
  assign in_valid[0]  = p_in_valid;
  assign p_in_ready   = in_ready[0];
  assign p_out_data   = out_data[0];
  assign p_out_valid  = out_valid[0];
  assign out_ready[0] = p_out_ready;

  for (genvar k = 0; k < NUM_CHILD; k++) begin : g_child_map
    assign in_data[k+1]                 = c_in_data[k*WIDTH +: WIDTH];
    assign in_valid[k+1]                = c_in_valid[k];
    assign c_in_ready[k]                = in_ready[k+1];
    assign c_out_data[k*WIDTH +: WIDTH] = out_data[k+1];
    assign c_out_valid[k]               = out_valid[k+1];
    assign out_ready[k+1]               = c_out_ready[k];
  end

  // Destination decode of every input's head flit.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      route[i] = route_of(dest_of(flit_t'(in_data[i]), WIDTH, WIDTH_ADDR),
                          addr_t'(MASK), addr_t'(ADDRESS), CHILD_SHIFT, NUM_CHILD, (i == 0));
    end
  end

  // Requests per output; an output with a full FIFO raises no candidates.
  always_comb begin
    for (int o = 0; o < P; o++) begin
      for (int i = 0; i < P; i++) begin
        cand[o][i] = !fifo_full[o] && in_valid[i] && (route[i] == port_idx_t'(o));
      end
    end
  end

  // Round-robin: first scan indices above the last grant, then wrap to the rest.
  always_comb begin
    for (int o = 0; o < P; o++) begin
      gnt[o]     = '0;
      gnt_idx[o] = '0;
      gnt_any[o] = 1'b0;
      for (int i = 0; i < P; i++) begin
        if (!gnt_any[o] && cand[o][i] && (port_idx_t'(i) > rr_ptr[o])) begin
          gnt[o][i]  = 1'b1;
          gnt_idx[o] = port_idx_t'(i);
          gnt_any[o] = 1'b1;
        end
      end
      for (int i = 0; i < P; i++) begin
        if (!gnt_any[o] && cand[o][i] && (port_idx_t'(i) <= rr_ptr[o])) begin
          gnt[o][i]  = 1'b1;
          gnt_idx[o] = port_idx_t'(i);
          gnt_any[o] = 1'b1;
        end
      end
    end
  end

  // Input ready: granted somewhere, or an out-of-subtree parent flit being discarded.
  always_comb begin
    drop     = in_valid[0] && (route[0] == PORT_INVALID);
    in_ready = '0;
    for (int o = 0; o < P; o++) begin
      in_ready = in_ready | gnt[o];
    end
    in_ready[0] = in_ready[0] | drop;
  end

  // Select the winning input's flit for each output FIFO.
  always_comb begin
    for (int o = 0; o < P; o++) begin
      push_data[o] = '0;
      for (int i = 0; i < P; i++) begin
        if (gnt[o][i]) begin
          push_data[o] = in_data[i];
        end
      end
    end
  end

  // Priority pointers move only when their output grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < P; o++) begin
        rr_ptr[o] <= port_idx_t'(P - 1);
      end
    end else begin
      for (int o = 0; o < P; o++) begin
        if (gnt_any[o]) begin
          rr_ptr[o] <= gnt_idx[o];
        end
      end
    end
  end

  // Sticky flag for discarded parent flits.
  always_ff @(posedge clk) begin
    if (rst) begin
      route_err <= 1'b0;
    end else if (drop) begin
      route_err <= 1'b1;
    end
  end

  for (genvar o = 0; o < P; o++) begin : g_out
    assign pop[o]       = out_ready[o] && !fifo_empty[o];
    assign out_valid[o] = (fifo_count[o] != '0);

    noc_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (gnt_any[o]),
      .wdata (push_data[o]),
      .pop   (pop[o]),
      .rdata (out_data[o]),
      .count (fifo_count[o]),
      .full  (fifo_full[o]),
      .empty (fifo_empty[o])
    );
  end

`ifdef NOC_ROUTER_STATS_EN
  logic [15:0] fwd_cnt [P];
  logic [15:0] drop_cnt;

  // Saturating forward counters per output and a saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < P; o++) begin
        fwd_cnt[o] <= '0;
      end
      drop_cnt <= '0;
    end else begin
      for (int o = 0; o < P; o++) begin
        if (pop[o] && (fwd_cnt[o] != 16'hFFFF)) begin
          fwd_cnt[o] <= fwd_cnt[o] + 16'd1;
        end
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  for (genvar o = 0; o < P; o++) begin : g_stat
    assign stat_fwd[o*16 +: 16] = fwd_cnt[o];
  end
  assign stat_drop = drop_cnt;
`endif

endmodule

// File: tb/tb_noc_tree_router.sv
// tb/tb_noc_tree_router.sv - self-checking bench for noc_tree_router
module tb_noc_tree_router;

  localparam int W      = 35;
  localparam int WA     = 3;
  localparam int NC     = 2;
  localparam int P      = NC + 1;
  localparam int DEPTH  = 4;
  localparam int MASK_I = 6;
  localparam int ADDR_I = 2;
  localparam int CS     = 0;

  logic            clk;
  logic            rst;
  logic [W-1:0]    p_in_data;
  logic            p_in_valid;
  logic            p_in_ready;
  logic [W-1:0]    p_out_data;
  logic            p_out_valid;
  logic            p_out_ready;
  logic [NC*W-1:0] c_in_data;
  logic [NC-1:0]   c_in_valid;
  logic [NC-1:0]   c_in_ready;
  logic [NC*W-1:0] c_out_data;
  logic [NC-1:0]   c_out_valid;
  logic [NC-1:0]   c_out_ready;
  logic            route_err;
`ifdef NOC_ROUTER_STATS_EN
  logic [P*16-1:0] stat_fwd;
  logic [15:0]     stat_drop;
`endif

  int total = 0;
  int bad   = 0;

  noc_tree_router #(
    .WIDTH       (W),
    .WIDTH_ADDR  (WA),
    .NUM_CHILD   (NC),
    .MASK        (3'b110),
    .ADDRESS     (3'b010),
    .CHILD_SHIFT (CS),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p_in_data   (p_in_data),
    .p_in_valid  (p_in_valid),
    .p_in_ready  (p_in_ready),
    .p_out_data  (p_out_data),
    .p_out_valid (p_out_valid),
    .p_out_ready (p_out_ready),
    .c_in_data   (c_in_data),
    .c_in_valid  (c_in_valid),
    .c_in_ready  (c_in_ready),
    .c_out_data  (c_out_data),
    .c_out_valid (c_out_valid),
    .c_out_ready (c_out_ready),
    .route_err   (route_err)
`ifdef NOC_ROUTER_STATS_EN
    ,
    .stat_fwd    (stat_fwd),
    .stat_drop   (stat_drop)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Destination rule: in-subtree goes to child, otherwise parent (from child) or drop (-1).
  function automatic int m_route(input int src, input logic [W-1:0] f);
    int d;
    d = int'(f >> (W - WA));
    if ((d & MASK_I) == (ADDR_I & MASK_I)) return ((d >> CS) % NC) + 1;
    return (src == 0) ? -1 : 0;
  endfunction

  function automatic logic [W-1:0] flit(input logic [2:0] d, input logic [31:0] pl);
    return {d, pl};
  endfunction

  // ---------------- reference model ----------------
  logic [W-1:0] mq [P][$];
  int           m_last [P];
  bit           m_err;
  int           m_fwd [P];
  int           m_drop;
  bit           model_on = 0;

  initial begin : model
    logic [W-1:0] sd [P];
    logic         sv [P];
    logic         sr [P];
    int           g [P];
    logic [P-1:0] er;
    logic [P-1:0] ev;
    bit           dropping;
    int           s;
    for (int o = 0; o < P; o++) begin
      m_last[o] = P - 1;
      m_fwd[o]  = 0;
    end
    m_err  = 0;
    m_drop = 0;
    forever begin
      @(negedge clk);
      sd[0] = p_in_data;
      sv[0] = p_in_valid;
      sr[0] = p_out_ready;
      for (int k = 0; k < NC; k++) begin
        sd[k+1] = c_in_data[k*W +: W];
        sv[k+1] = c_in_valid[k];
        sr[k+1] = c_out_ready[k];
      end
      er = '0;
      dropping = 0;
      for (int o = 0; o < P; o++) begin
        g[o] = -1;
        ev[o] = (mq[o].size() != 0);
        if (mq[o].size() < DEPTH) begin
          for (int k = 1; k <= P; k++) begin
            s = (m_last[o] + k) % P;
            if (g[o] < 0 && sv[s] && m_route(s, sd[s]) == o) begin
              g[o] = s;
              er[s] = 1'b1;
            end
          end
        end
      end
      if (sv[0] && m_route(0, sd[0]) < 0) begin
        dropping = 1;
        er[0] = 1'b1;
      end
      if (model_on) begin
        chk("m_p_in_ready", p_in_ready, er[0]);
        chk("m_c_in_ready", c_in_ready, er[P-1:1]);
        chk("m_out_valid", {c_out_valid, p_out_valid}, ev);
        if (ev[0]) chk("m_p_out_data", p_out_data, mq[0][0]);
        for (int k = 0; k < NC; k++) begin
          if (ev[k+1]) chk("m_c_out_data", c_out_data[k*W +: W], mq[k+1][0]);
        end
        chk("m_route_err", route_err, m_err);
`ifdef NOC_ROUTER_STATS_EN
        for (int o = 0; o < P; o++) chk("m_stat_fwd", stat_fwd[o*16 +: 16], m_fwd[o]);
        chk("m_stat_drop", stat_drop, m_drop);
`endif
      end
      @(posedge clk);
      if (rst) begin
        for (int o = 0; o < P; o++) begin
          mq[o].delete();
          m_last[o] = P - 1;
          m_fwd[o]  = 0;
        end
        m_err  = 0;
        m_drop = 0;
      end else begin
        for (int o = 0; o < P; o++) begin
          if (ev[o] && sr[o]) begin
            void'(mq[o].pop_front());
            if (m_fwd[o] < 65535) m_fwd[o]++;
          end
        end
        for (int o = 0; o < P; o++) begin
          if (g[o] >= 0) begin
            mq[o].push_back(sd[g[o]]);
            m_last[o] = g[o];
          end
        end
        if (dropping) begin
          m_err = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_in_valid = 1'b0;
    p_in_data  = '0;
    c_in_valid = '0;
    c_in_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin : main
    logic [5:0]   seq_p;
    logic [5:0]   seq_c;
    logic [W-1:0] got [$];
    logic [W-1:0] exp5 [5];
    int np, nc, n, acc;

    exp5 = '{35'h2_0000_0500, 35'h2_0000_0501, 35'h2_0000_0502, 35'h2_0000_0503, 35'h2_0000_0504};
    rst = 1'b1;
    p_out_ready = 1'b1;
    c_out_ready = '1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    model_on = 1;

    // reset state
    @(negedge clk);
    chk("rst_p_out_valid", p_out_valid, 0);
    chk("rst_c_out_valid", c_out_valid, 0);
    chk("rst_p_in_ready", p_in_ready, 0);
    chk("rst_c_in_ready", c_in_ready, 0);
    chk("rst_route_err", route_err, 0);
    chk("rst_p_out_data", p_out_data, 0);
    chk("rst_c_out_data", c_out_data, 0);

    // parent -> child 1
    tick();
    p_in_data  = 35'h3_0000_00AA;
    p_in_valid = 1'b1;
    @(negedge clk);
    chk("t1_p_in_ready", p_in_ready, 1);
    tick();
    idle();
    @(negedge clk);
    chk("t1_c_out_valid", c_out_valid, 2'b10);
    chk("t1_c1_data", c_out_data[2*W-1:W], 35'h3_0000_00AA);
    chk("t1_p_out_valid", p_out_valid, 0);

    // child 0 -> parent
    tick();
    c_in_data[W-1:0] = flit(3'b100, 32'h55);
    c_in_valid = 2'b01;
    tick();
    idle();
    @(negedge clk);
    chk("t2_p_out_valid", p_out_valid, 1);
    chk("t2_p_out_data", p_out_data, 35'h4_0000_0055);
    chk("t2_c_out_valid", c_out_valid, 0);

    // child 1 -> child 0
    tick();
    c_in_data[2*W-1:W] = flit(3'b010, 32'h77);
    c_in_valid = 2'b10;
    tick();
    idle();
    @(negedge clk);
    chk("t2b_c_out_valid", c_out_valid, 2'b01);
    chk("t2b_c0_data", c_out_data[W-1:0], 35'h2_0000_0077);

    // unroutable parent flit
    tick();
    p_in_data  = flit(3'b100, 32'h99);
    p_in_valid = 1'b1;
    @(negedge clk);
    chk("t3_p_in_ready", p_in_ready, 1);
    chk("t3_err_before", route_err, 0);
    tick();
    idle();
    @(negedge clk);
    chk("t3_route_err", route_err, 1);
    chk("t3_no_output", {c_out_valid, p_out_valid}, 0);
`ifdef NOC_ROUTER_STATS_EN
    chk("t3_stat_drop", stat_drop, 1);
`endif
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("t3_route_err_sticky", route_err, 1);

    // round-robin between parent and child 1 into child 0
    do_reset();
    np = 0;
    nc = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      p_in_data  = flit(3'b010, 32'h100 + np);
      p_in_valid = 1'b1;
      c_in_data[2*W-1:W] = flit(3'b010, 32'h200 + nc);
      c_in_valid = 2'b10;
      @(negedge clk);
      seq_p[cyc] = p_in_ready;
      seq_c[cyc] = c_in_ready[1];
      if (p_in_ready) np++;
      if (c_in_ready[1]) nc++;
      tick();
    end
    idle();
    chk("t4_parent_grants", seq_p, 6'b010101);
    chk("t4_child1_grants", seq_c, 6'b101010);
    tick();
    tick();

    // backpressure on child 0 with five offered flits
    c_out_ready = 2'b10;
    n = 0;
    acc = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc == 8) c_out_ready = 2'b11;
      p_in_valid = (n < 5);
      p_in_data  = flit(3'b010, 32'h500 + n);
      @(negedge clk);
      if (cyc == 7) begin
        chk("t5_accepted_blocked", acc, 4);
        chk("t5_fifth_held", p_in_ready, 0);
      end
      if (p_in_valid && p_in_ready) begin
        acc++;
        n++;
      end
      if (c_out_valid[0] && c_out_ready[0]) got.push_back(c_out_data[W-1:0]);
      tick();
    end
    idle();
    chk("t5_accepted_total", acc, 5);
    chk("t5_drained_count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk("t5_drain_order", got[i], exp5[i]);
    end

    // reset with buffered flits
    c_out_ready = 2'b00;
    p_in_data  = flit(3'b100, 32'h66);
    p_in_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      p_in_data = flit(3'b010, 32'h600 + i);
      tick();
    end
    idle();
    @(negedge clk);
    chk("t6_buffered", c_out_valid, 2'b01);
    chk("t6_err_set", route_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_c_out_valid", c_out_valid, 0);
    chk("t6_rst_p_out_valid", p_out_valid, 0);
    chk("t6_rst_route_err", route_err, 0);
    c_out_ready = 2'b11;
    tick();
    @(negedge clk);
    chk("t6_fifo_empty", c_out_valid, 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
